// File: rtl/xif_commit_queue_pkg.sv
// Shared CORE-V-XIF types used by the offload commit queue and the result-path
// tracker: issue/commit payloads, the decoder verdict and per-slot bookkeeping.
package xif_commit_queue_pkg;

    localparam int X_ID_WIDTH  = 4;
    localparam int X_NUM_RS    = 2;
    localparam int X_RFR_WIDTH = 32;

    typedef struct packed {
        logic [31:0]                           instr;
        logic [1:0]                            mode;
        logic [X_ID_WIDTH-1:0]                 id;
        logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]  rs;
        logic [X_NUM_RS-1:0]                   rs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic dualwrite;
        logic dualread;
        logic loadstore;
        logic exc;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    typedef enum logic [1:0] {
        SLOT_FREE      = 2'd0,
        SLOT_WAIT      = 2'd1,
        SLOT_COMMITTED = 2'd2,
        SLOT_KILLED    = 2'd3
    } xif_slot_state_e;

    typedef struct packed {
        xif_slot_state_e state;
        x_issue_req_t    payload;
    } xif_slot_t;

    // State a slot takes once the core has resolved it.
    function automatic xif_slot_state_e resolve_state(input logic kill);
        return kill ? SLOT_KILLED : SLOT_COMMITTED;
    endfunction

endpackage

// File: rtl/xif_commit_queue_if.sv
// Bundle of the issue, commit and dispatch channels around the commit queue.
// master = core / execution-unit side, slave = the queue itself.
interface xif_commit_queue_if #(
    parameter int Depth = 4
);
    import xif_commit_queue_pkg::*;

    localparam int OccW = $clog2(Depth + 1);

    logic          issue_valid_i;
    logic          issue_ready_o;
    x_issue_req_t  issue_req_i;
    x_issue_resp_t dec_resp_i;
    x_issue_resp_t issue_resp_o;
    logic          commit_valid_i;
    x_commit_t     commit_i;
    logic          disp_valid_o;
    logic          disp_ready_i;
    x_issue_req_t  disp_req_o;
    logic [OccW-1:0] occupancy_o;
    logic          commit_miss_o;

    modport master (
        output issue_valid_i, issue_req_i, dec_resp_i, commit_valid_i, commit_i, disp_ready_i,
        input  issue_ready_o, issue_resp_o, disp_valid_o, disp_req_o, occupancy_o, commit_miss_o
    );

    modport slave (
        input  issue_valid_i, issue_req_i, dec_resp_i, commit_valid_i, commit_i, disp_ready_i,
        output issue_ready_o, issue_resp_o, disp_valid_o, disp_req_o, occupancy_o, commit_miss_o
    );

endinterface

// File: rtl/xif_commit_queue.sv
// In-order holding queue for offloaded instructions: entries wait for the core's
// commit/kill verdict and leave strictly in issue order; killed entries are
// dropped at the head without ever reaching the execution unit.
module xif_commit_queue
    import xif_commit_queue_pkg::*;
#(
    parameter int Depth   = 4,
    parameter int IdWidth = X_ID_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    xif_commit_queue_if.slave bus
);

    localparam int PtrW = $clog2(Depth);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW-1:0] wr_idx, rd_idx;

    xif_slot_state_e state_q   [Depth];
    x_issue_req_t    payload_q [Depth];

    logic             full;
    logic             issue_ready;
    logic             enq;
    logic [IdWidth-1:0] commit_id;
    logic [Depth-1:0] match_vec;
    logic             enq_match;
    logic             miss_d;
    logic             miss_q;
    xif_slot_t        head_slot;
    logic             disp_valid;
    logic             pop;
    logic [PtrW:0]    occ;

    assign wr_idx      = wr_ptr_q[PtrW-1:0];
    assign rd_idx      = rd_ptr_q[PtrW-1:0];
    assign full        = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) && (wr_idx == rd_idx);
    assign occ         = wr_ptr_q - rd_ptr_q;
    assign issue_ready = !full;

    // A rejected request still completes its handshake but takes no slot.
    assign enq       = bus.issue_valid_i && issue_ready && bus.dec_resp_i.accept;
    assign commit_id = bus.commit_i.id;

    // CAM-style search: only slots still waiting for a verdict can be resolved.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < Depth; i++) begin
            match_vec[i] = bus.commit_valid_i && (state_q[i] == SLOT_WAIT) &&
                           (payload_q[i].id == commit_id);
        end
    end

    // A commit may target the instruction being issued in the same cycle.
    assign enq_match = bus.commit_valid_i && enq && (bus.issue_req_i.id == commit_id);
    assign miss_d    = bus.commit_valid_i && (match_vec == '0) && !enq_match;

    assign head_slot  = '{state: state_q[rd_idx], payload: payload_q[rd_idx]};
    assign disp_valid = (head_slot.state == SLOT_COMMITTED);
    // Killed heads retire silently; committed heads retire on the dispatch handshake.
    assign pop        = (disp_valid && bus.disp_ready_i) || (head_slot.state == SLOT_KILLED);

    // Decoder verdict passes through, but accept is withheld while the queue is full.
    always_comb begin
        bus.issue_resp_o        = bus.dec_resp_i;
        bus.issue_resp_o.accept = bus.dec_resp_i.accept && issue_ready;
    end

    assign bus.issue_ready_o = issue_ready;
    assign bus.disp_valid_o  = disp_valid;
    assign bus.disp_req_o    = disp_valid ? head_slot.payload : '0;
    assign bus.occupancy_o   = occ;
    assign bus.commit_miss_o = miss_q;

    // Slot states, pointers and the miss pulse: enqueue, resolve and retire.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            miss_q   <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                state_q[i] <= SLOT_FREE;
            end
        end else begin
            miss_q <= miss_d;
            if (enq) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            for (int i = 0; i < Depth; i++) begin
                if (enq && (PtrW'(i) == wr_idx)) begin
                    state_q[i] <= enq_match ? resolve_state(bus.commit_i.commit_kill) : SLOT_WAIT;
                end else if (pop && (PtrW'(i) == rd_idx)) begin
                    state_q[i] <= SLOT_FREE;
                end else if (match_vec[i]) begin
                    state_q[i] <= resolve_state(bus.commit_i.commit_kill);
                end
            end
        end
    end

    // Payload storage needs no reset: it is only visible behind a non-FREE state.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            payload_q[wr_idx] <= bus.issue_req_i;
        end
    end

`ifndef SYNTHESIS
    logic         hold_q;
    x_issue_req_t req_prev_q;
    logic         dup_live;

    // Two occupied slots sharing an id would make the commit search ambiguous.
    always_comb begin
        dup_live = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            for (int j = i + 1; j < Depth; j++) begin
                if ((state_q[i] != SLOT_FREE) && (state_q[j] != SLOT_FREE) &&
                    (payload_q[i].id == payload_q[j].id)) begin
                    dup_live = 1'b1;
                end
            end
        end
    end

    // Remember whether a dispatch was left pending at the last edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= disp_valid && !bus.disp_ready_i;
        end
    end

    // Snapshot of the dispatched payload for the stability check.
    always_ff @(posedge clk_i) begin
        req_prev_q <= bus.disp_req_o;
    end

    // Mid-cycle invariant checks, away from the state update edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            assert (!dup_live);
            assert (occ <= (PtrW + 1)'(Depth));
            if (hold_q) begin
                assert (disp_valid && (bus.disp_req_o == req_prev_q));
            end
        end
    end
`endif

endmodule

// File: tb/tb_xif_commit_queue.sv
// Bench for the offload commit queue: scripted corner-case sequences, a vector
// table, and randomized traffic checked against an ordered-list model.
module tb_xif_commit_queue;
    import xif_commit_queue_pkg::*;

    localparam int Depth = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xif_commit_queue_if #(.Depth(Depth)) bus ();

    xif_commit_queue #(.Depth(Depth)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid_i  = 1'b0;
        bus.issue_req_i    = '0;
        bus.dec_resp_i     = '0;
        bus.commit_valid_i = 1'b0;
        bus.commit_i       = '0;
        bus.disp_ready_i   = 1'b0;
    endtask

    task automatic issue(input int id, input logic acc);
        x_issue_req_t  r;
        x_issue_resp_t d;
        r          = '0;
        r.id       = X_ID_WIDTH'(id);
        r.instr    = 32'hC0DE_0000 | 32'(id);
        d          = '0;
        d.accept   = acc;
        bus.issue_valid_i = 1'b1;
        bus.issue_req_i   = r;
        bus.dec_resp_i    = d;
    endtask

    task automatic no_issue();
        bus.issue_valid_i = 1'b0;
        bus.dec_resp_i    = '0;
    endtask

    task automatic commit(input int id, input logic kill);
        x_commit_t c;
        c.id          = X_ID_WIDTH'(id);
        c.commit_kill = kill;
        bus.commit_valid_i = 1'b1;
        bus.commit_i       = c;
    endtask

    task automatic no_commit();
        bus.commit_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       iv, acc;
        logic [3:0] iid;
        logic       cv;
        logic [3:0] cid;
        logic       kill, dr;
        logic       e_rdy, e_dv;
        logic [3:0] e_did;
        logic [2:0] e_occ;
        logic       e_miss;
    } vec_t;

    function automatic vec_t mk(input int iv, input int acc, input int iid, input int cv,
                                input int cid, input int kill, input int dr, input int rdy,
                                input int dv, input int did, input int occ, input int miss);
        vec_t v;
        v.iv = 1'(iv); v.acc = 1'(acc); v.iid = 4'(iid);
        v.cv = 1'(cv); v.cid = 4'(cid); v.kill = 1'(kill); v.dr = 1'(dr);
        v.e_rdy = 1'(rdy); v.e_dv = 1'(dv); v.e_did = 4'(did);
        v.e_occ = 3'(occ); v.e_miss = 1'(miss);
        return v;
    endfunction

    task automatic run_table();
        vec_t vecs[10];
        //             iv acc iid cv cid k dr | rdy dv did occ miss  (state after the edge)
        vecs[0] = mk(1, 1, 1,  0, 0, 0, 0,   1, 0, 0, 1, 0);
        vecs[1] = mk(1, 1, 2,  1, 2, 0, 0,   1, 0, 0, 2, 0);
        vecs[2] = mk(0, 0, 0,  1, 1, 0, 0,   1, 1, 1, 2, 0);
        vecs[3] = mk(0, 0, 0,  0, 0, 0, 0,   1, 1, 1, 2, 0);
        vecs[4] = mk(0, 0, 0,  0, 0, 0, 1,   1, 1, 2, 1, 0);
        vecs[5] = mk(1, 0, 3,  0, 0, 0, 1,   1, 0, 0, 0, 0);
        vecs[6] = mk(0, 0, 0,  1, 5, 0, 0,   1, 0, 0, 0, 1);
        vecs[7] = mk(0, 0, 0,  0, 0, 0, 0,   1, 0, 0, 0, 0);
        vecs[8] = mk(1, 1, 4,  1, 4, 1, 0,   1, 0, 0, 1, 0);
        vecs[9] = mk(0, 0, 0,  0, 0, 0, 0,   1, 0, 0, 0, 0);
        do_reset();
        for (int k = 0; k < 10; k++) begin
            idle();
            if (vecs[k].iv) issue(int'(vecs[k].iid), vecs[k].acc);
            if (vecs[k].cv) commit(int'(vecs[k].cid), vecs[k].kill);
            bus.disp_ready_i = vecs[k].dr;
            tick();
            check($sformatf("vec%0d_ready", k), 64'(bus.issue_ready_o), 64'(vecs[k].e_rdy));
            check($sformatf("vec%0d_dvalid", k), 64'(bus.disp_valid_o), 64'(vecs[k].e_dv));
            check($sformatf("vec%0d_occ", k), 64'(bus.occupancy_o), 64'(vecs[k].e_occ));
            check($sformatf("vec%0d_miss", k), 64'(bus.commit_miss_o), 64'(vecs[k].e_miss));
            if (vecs[k].e_dv)
                check($sformatf("vec%0d_did", k), 64'(bus.disp_req_o.id), 64'(vecs[k].e_did));
        end
        idle();
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  id;
        logic [31:0] instr;
        int          st;    // 0 awaiting verdict, 1 committed, 2 killed
    } ent_t;

    ent_t model_q[$];

    function automatic bit is_live(input logic [3:0] id);
        foreach (model_q[k]) if (model_q[k].id == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_random(input int cycles);
        logic          miss_pend;
        logic          iv, acc, cv, kill, dr, exp_rdy, exp_dv, enq, found, do_pop;
        logic [3:0]    iid, cid;
        logic [31:0]   instr;
        x_issue_req_t  r;
        x_issue_resp_t d, exp_resp;
        int            waits[$];
        ent_t          e;
        do_reset();
        model_q.delete();
        miss_pend = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            iv    = ($urandom_range(0, 99) < 50);
            acc   = ($urandom_range(0, 9) < 8);
            iid   = 4'($urandom_range(0, 15));
            while (is_live(iid)) iid = iid + 4'd1;
            instr = $urandom;
            cv    = ($urandom_range(0, 99) < 40);
            kill  = ($urandom_range(0, 99) < 30);
            dr    = ($urandom_range(0, 99) < 70);
            waits.delete();
            foreach (model_q[k]) if (model_q[k].st == 0) waits.push_back(k);
            if (waits.size() > 0 && $urandom_range(0, 99) < 70)
                cid = model_q[waits[$urandom_range(0, waits.size() - 1)]].id;
            else if (iv && $urandom_range(0, 99) < 30)
                cid = iid;
            else
                cid = 4'($urandom_range(0, 15));

            r = '0; r.id = iid; r.instr = instr; r.mode = 2'($urandom);
            d = x_issue_resp_t'(6'($urandom)); d.accept = acc;
            bus.issue_valid_i  = iv;
            bus.issue_req_i    = r;
            bus.dec_resp_i     = d;
            bus.commit_valid_i = cv;
            bus.commit_i.id    = cid;
            bus.commit_i.commit_kill = kill;
            bus.disp_ready_i   = dr;
            #1;

            exp_rdy = (model_q.size() < Depth);
            exp_dv  = (model_q.size() > 0) && (model_q[0].st == 1);
            exp_resp = d;
            exp_resp.accept = acc && exp_rdy;
            check("rnd_ready", 64'(bus.issue_ready_o), 64'(exp_rdy));
            check("rnd_dvalid", 64'(bus.disp_valid_o), 64'(exp_dv));
            check("rnd_occ", 64'(bus.occupancy_o), 64'(model_q.size()));
            check("rnd_miss", 64'(bus.commit_miss_o), 64'(miss_pend));
            check("rnd_resp", 64'(bus.issue_resp_o), 64'(exp_resp));
            if (exp_dv) begin
                check("rnd_did", 64'(bus.disp_req_o.id), 64'(model_q[0].id));
                check("rnd_dinstr", 64'(bus.disp_req_o.instr), 64'(model_q[0].instr));
            end

            // Advance the model by the ordering rules.
            do_pop = (model_q.size() > 0) &&
                     ((model_q[0].st == 1 && dr) || model_q[0].st == 2);
            enq   = iv && exp_rdy && acc;
            found = 1'b0;
            if (cv) begin
                foreach (model_q[k]) begin
                    if (model_q[k].st == 0 && model_q[k].id == cid) begin
                        model_q[k].st = kill ? 2 : 1;
                        found = 1'b1;
                    end
                end
            end
            if (do_pop) void'(model_q.pop_front());
            if (enq) begin
                e.id = iid; e.instr = instr; e.st = 0;
                if (cv && !found && cid == iid) begin
                    e.st  = kill ? 2 : 1;
                    found = 1'b1;
                end
                model_q.push_back(e);
            end
            miss_pend = cv && !found;
            @(posedge clk);
            #1;
        end
        idle();
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        int disp_cnt;
        logic [3:0] disp_id;
        rst = 1'b0;
        idle();

        // Reset state, then same-cycle issue + commit on an empty queue.
        do_reset();
        check("rst_ready", 64'(bus.issue_ready_o), 64'd1);
        check("rst_dvalid", 64'(bus.disp_valid_o), 64'd0);
        check("rst_occ", 64'(bus.occupancy_o), 64'd0);
        check("rst_miss", 64'(bus.commit_miss_o), 64'd0);
        check("rst_dreq_zero", 64'(bus.disp_req_o == '0), 64'd1);
        issue(3, 1'b1);
        commit(3, 1'b0);
        tick();
        no_issue(); no_commit();
        check("t1_dvalid", 64'(bus.disp_valid_o), 64'd1);
        check("t1_did", 64'(bus.disp_req_o.id), 64'd3);
        check("t1_occ", 64'(bus.occupancy_o), 64'd1);
        bus.disp_ready_i = 1'b1;
        tick();
        check("t1_occ_after_pop", 64'(bus.occupancy_o), 64'd0);
        check("t1_dvalid_after_pop", 64'(bus.disp_valid_o), 64'd0);

        // Fill to capacity, reject a fifth request, then drain one.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            issue(i, 1'b1);
            #1;
            check("t2_accept", 64'(bus.issue_resp_o.accept), 64'd1);
            tick();
        end
        issue(5, 1'b1);
        #1;
        check("t2_full_ready", 64'(bus.issue_ready_o), 64'd0);
        check("t2_full_accept", 64'(bus.issue_resp_o.accept), 64'd0);
        tick();
        no_issue();
        check("t2_full_occ", 64'(bus.occupancy_o), 64'd4);
        commit(1, 1'b0);
        bus.disp_ready_i = 1'b1;
        tick();
        no_commit();
        check("t2_dvalid", 64'(bus.disp_valid_o), 64'd1);
        check("t2_did", 64'(bus.disp_req_o.id), 64'd1);
        check("t2_ready_still_full", 64'(bus.issue_ready_o), 64'd0);
        tick();
        check("t2_ready_after_pop", 64'(bus.issue_ready_o), 64'd1);
        check("t2_occ_after_pop", 64'(bus.occupancy_o), 64'd3);

        // Out-of-order commits still dispatch in issue order.
        do_reset();
        issue(5, 1'b1); tick();
        issue(6, 1'b1); tick();
        no_issue();
        commit(6, 1'b0); tick();
        no_commit();
        check("t3_blocked", 64'(bus.disp_valid_o), 64'd0);
        tick();
        check("t3_blocked_idle", 64'(bus.disp_valid_o), 64'd0);
        commit(5, 1'b0); tick();
        no_commit();
        check("t3_first_dvalid", 64'(bus.disp_valid_o), 64'd1);
        check("t3_first_id", 64'(bus.disp_req_o.id), 64'd5);
        bus.disp_ready_i = 1'b1;
        tick();
        check("t3_second_dvalid", 64'(bus.disp_valid_o), 64'd1);
        check("t3_second_id", 64'(bus.disp_req_o.id), 64'd6);
        tick();
        check("t3_drained", 64'(bus.occupancy_o), 64'd0);

        // Kills are dropped; only the committed entry reaches the execution unit.
        do_reset();
        bus.disp_ready_i = 1'b1;
        disp_cnt = 0;
        disp_id  = '0;
        issue(7, 1'b1); tick();
        issue(8, 1'b1); tick();
        issue(9, 1'b1); tick();
        no_issue();
        commit(7, 1'b1); tick();
        check("t4_killed_head", 64'(bus.disp_valid_o), 64'd0);
        commit(8, 1'b0); tick();
        if (bus.disp_valid_o) begin disp_cnt++; disp_id = bus.disp_req_o.id; end
        commit(9, 1'b1); tick();
        no_commit();
        for (int k = 0; k < 3 && bus.occupancy_o != 0; k++) begin
            if (bus.disp_valid_o) begin disp_cnt++; disp_id = bus.disp_req_o.id; end
            tick();
        end
        check("t4_occ_zero", 64'(bus.occupancy_o), 64'd0);
        check("t4_disp_count", 64'(disp_cnt), 64'd1);
        check("t4_disp_id", 64'(disp_id), 64'd8);

        // Rejected issue stores nothing; commit of an absent id pulses miss once.
        do_reset();
        issue(2, 1'b0);
        #1;
        check("t5_reject_accept", 64'(bus.issue_resp_o.accept), 64'd0);
        tick();
        no_issue();
        check("t5_occ", 64'(bus.occupancy_o), 64'd0);
        commit(2, 1'b0); tick();
        no_commit();
        check("t5_miss_pulse", 64'(bus.commit_miss_o), 64'd1);
        tick();
        check("t5_miss_cleared", 64'(bus.commit_miss_o), 64'd0);

        // Asynchronous reset in the middle of a stalled dispatch.
        do_reset();
        for (int i = 10; i < 13; i++) begin
            issue(i, 1'b1);
            commit(i, 1'b0);
            tick();
        end
        no_issue(); no_commit();
        check("t6_pre_occ", 64'(bus.occupancy_o), 64'd3);
        check("t6_pre_dvalid", 64'(bus.disp_valid_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_occ", 64'(bus.occupancy_o), 64'd0);
        check("t6_async_dvalid", 64'(bus.disp_valid_o), 64'd0);
        check("t6_async_ready", 64'(bus.issue_ready_o), 64'd1);
        #1;
        rst = 1'b0;
        tick();
        check("t6_post_occ", 64'(bus.occupancy_o), 64'd0);

        run_table();
        run_random(600);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/xif_commit_queue.md
Name: xif_commit_queue

Overview:
- In-order holding queue between the core-side CORE-V-XIF issue/commit interfaces and the coprocessor execution unit.
- Stores each accepted offloaded instruction until the core commits it, then dispatches it in issue order.
- Drops killed instructions without dispatching them, so speculative work never reaches the execution unit.

Parameters:
- Depth, 4: number of queue slots; power of two, at least 2.
- IdWidth, X_ID_WIDTH (4): width of the instruction ID; taken from the shared XIF package.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- issue_valid_i  in  1  core issue request valid.
- issue_ready_o  out  1  queue can take an issue request.
- issue_req_i  in  x_issue_req_t  instr, mode, id, rs, rs_valid.
- dec_resp_i  in  x_issue_resp_t  combinational decoder verdict for issue_req_i.instr.
- issue_resp_o  out  x_issue_resp_t  equals dec_resp_i, with accept forced 0 when issue_ready_o=0.
- commit_valid_i  in  1  commit strobe (single cycle, no ready).
- commit_i  in  x_commit_t  id, commit_kill.
- disp_valid_o  out  1  head instruction committed and ready to execute.
- disp_ready_i  in  1  execution unit takes the head instruction.
- disp_req_o  out  x_issue_req_t  head entry payload.
- occupancy_o  out  $clog2(Depth+1)  number of non-FREE slots.
- commit_miss_o  out  1  one-cycle pulse: commit id matched no WAIT slot.

Behaviour:
- Reset: all slots FREE; read and write pointers 0.
  - Outputs at reset: issue_ready_o=1, disp_valid_o=0, occupancy_o=0, commit_miss_o=0, disp_req_o=0.
- Slot states: FREE, WAIT, COMMITTED, KILLED. Each slot stores its x_issue_req_t payload and id.
- Enqueue:
  - issue_ready_o = (occupancy_o < Depth). It depends only on registered state; there is no same-cycle pop fall-through.
  - A handshake occurs when issue_valid_i & issue_ready_o.
  - If dec_resp_i.accept=1, write the slot at the write pointer with state WAIT and advance the pointer.
  - If accept=0, the handshake completes but nothing is stored.
- Commit:
  - When commit_valid_i is high, the slot in WAIT whose id equals commit_i.id moves to COMMITTED (kill=0) or KILLED (kill=1).
  - The same-cycle case counts: if the enqueuing entry carries the same id, it is written directly as COMMITTED or KILLED.
  - If no WAIT slot and no enqueuing entry matches, commit_miss_o pulses the next cycle and state is unchanged.
  - Commit for an id whose slot is already COMMITTED or KILLED: treated as a miss.
- Head processing, at most one pop per cycle:
  - Head COMMITTED: disp_valid_o=1 and disp_req_o = head payload. Pop on disp_ready_i.
  - Head KILLED: pop silently; disp_valid_o=0 that cycle.
  - Head WAIT or FREE: no pop; disp_valid_o=0. Later COMMITTED slots still wait behind it (strict in-order).
- Latency: commit at cycle t on the head slot gives disp_valid_o=1 at t+1. An issue plus commit in the same cycle t on an empty queue gives dispatch at t+1.
- Once disp_valid_o=1 it stays high with stable disp_req_o until disp_ready_i (AXI-style). A kill cannot target a COMMITTED slot.
- Simultaneous enqueue and pop: both happen; occupancy unchanged.
- Wrap-around: pointers are log2(Depth)+1 bits. Full when the MSBs differ and the LSBs are equal; empty when the pointers are equal.
- Reset mid-operation clears all slots immediately, since the reset is asynchronous. In-flight dispatch is abandoned; the execution unit is reset together with the queue.
- Simulation assertions:
  - no duplicate live ids;
  - disp_req_o stable while disp_valid_o & !disp_ready_i;
  - occupancy_o ≤ Depth.

Decomposition:
- The x_issue_req_t, x_issue_resp_t and x_commit_t typedefs, and X_ID_WIDTH, come from the shared CORE-V-XIF package.
- The slot-state enum (xif_slot_state_e, 2 bits) and the slot struct (state + payload) are added to that same package for reuse by the result-path tracker.
- No sub-module: the storage array, CAM-style id match and pointers fit in one module (about 200 lines).

Test Plan:
1. Reset, then issue id=3 accept=1 with commit id=3 kill=0 in the same cycle → disp_valid_o=1 next cycle, disp_req_o.id=3, occupancy_o=1; pop with disp_ready_i=1 → occupancy_o=0.
2. Issue ids 1,2,3,4 (Depth=4) with no commits → issue_ready_o=0 and issue_resp_o.accept=0 on a fifth request. Commit id=1 and hold disp_ready_i=1 → id 1 dispatched, issue_ready_o=1 the following cycle.
3. Issue ids 5,6; commit 6 then 5 → dispatch order 5 then 6; disp_valid_o stays low until the id 5 commit.
4. Issue ids 7,8,9; kill 7, commit 8, kill 9 → only id 8 dispatched; occupancy reaches 0 within 3 cycles after the last commit.
5. Issue with dec_resp_i.accept=0 → handshake completes, occupancy_o unchanged. Commit for an absent id=2 → commit_miss_o=1 for exactly one cycle.
6. Fill 3 slots, commit all, assert rst_i mid-dispatch with disp_ready_i=0 → occupancy_o=0 and disp_valid_o=0 immediately, independent of the clock edge.
